// File: rtl/hazard_scoreboard_if.sv
// Signal bundle between the ID-stage control logic and the hazard scoreboard.
// The core drives instruction/writeback status; the unit returns stall controls and scoreboard state.
interface hazard_scoreboard_if #(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned CNT_W       = 16
);
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_is_load;
  logic              id_branch;
  logic              ex_regwrite;
  logic [REG_AW-1:0] ex_rd;
  logic              wb_load_done;
  logic [REG_AW-1:0] wb_rd;
  logic              mem_stall;
  logic              flush;

  logic                pc_write;
  logic                if_id_write;
  logic                ctrl_enable;
  logic                hazard;
  logic [NUM_REGS-1:0] busy_vec;
  logic [PEND_W-1:0]   pending_cnt;
  logic [CNT_W-1:0]    stall_cnt;
  logic                err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_is_load, id_branch,
           ex_regwrite, ex_rd, wb_load_done, wb_rd, mem_stall, flush,
    input  pc_write, if_id_write, ctrl_enable, hazard, busy_vec, pending_cnt, stall_cnt, err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_is_load, id_branch,
           ex_regwrite, ex_rd, wb_load_done, wb_rd, mem_stall, flush,
    output pc_write, if_id_write, ctrl_enable, hazard, busy_vec, pending_cnt, stall_cnt, err
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Per-register load scoreboard hazard unit: stalls ID on pending loads of any latency,
// on branch operands still in EX, and when the outstanding-load limit is reached.
module hazard_scoreboard_unit #(
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MAX_PENDING = 4,
  parameter bit          WB_BYPASS   = 1'b1,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 255
) (
  input logic              clk,
  input logic              rst,
  hazard_scoreboard_if.slave bus
);
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
  localparam int unsigned WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [NUM_REGS-1:0] busy_q, busy_nxt;
  logic [PEND_W-1:0]   pend_q, pend_nxt;
  logic [CNT_W-1:0]    stall_q, stall_nxt;
  logic [WD_W-1:0]     wd_q, wd_nxt;
  logic                err_q, err_nxt;

  logic wb_hit1, wb_hit2;
  logic raw_load, raw_br, full;
  logic hazard, issue, set_busy, clr_busy, bad_clr, wd_expire;

  // A returning load can forward its data to the ID read in the same cycle.
  assign wb_hit1 = WB_BYPASS && bus.wb_load_done && (bus.wb_rd == bus.id_rs1);
  assign wb_hit2 = WB_BYPASS && bus.wb_load_done && (bus.wb_rd == bus.id_rs2);

  assign raw_load = (bus.id_use_rs1 && busy_q[bus.id_rs1] && !wb_hit1) ||
                    (bus.id_use_rs2 && busy_q[bus.id_rs2] && !wb_hit2);

  assign raw_br = bus.id_branch && bus.ex_regwrite && (bus.ex_rd != '0) &&
                  ((bus.id_use_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                   (bus.id_use_rs2 && (bus.ex_rd == bus.id_rs2)));

  assign full = bus.id_is_load && (pend_q == PEND_W'(MAX_PENDING)) && !bus.wb_load_done;

  assign hazard = !rst && bus.id_valid && !bus.flush && (raw_load || raw_br || full);
  assign issue  = bus.id_valid && !bus.flush && !hazard && !bus.mem_stall;

  assign set_busy = issue && bus.id_is_load && (bus.id_rd != '0);
  assign clr_busy = bus.wb_load_done && (bus.wb_rd != '0) && busy_q[bus.wb_rd];
  assign bad_clr  = bus.wb_load_done &&
                    ((bus.wb_rd == '0) ? (pend_q == '0) : !busy_q[bus.wb_rd]);

  assign wd_expire = (TIMEOUT != 0) && hazard && (wd_q == WD_W'(TIMEOUT - 1));

  // NOTE: every always_comb target gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    busy_nxt = busy_q;
    if (clr_busy) busy_nxt[bus.wb_rd] = 1'b0;
    // Applied after the clear so a same-register set/clear leaves the bit set.
    if (set_busy) busy_nxt[bus.id_rd] = 1'b1;

    pend_nxt = pend_q;
    unique case ({set_busy, clr_busy})
      2'b10:   pend_nxt = pend_q + PEND_W'(1);
      2'b01:   pend_nxt = pend_q - PEND_W'(1);
      default: pend_nxt = pend_q;
    endcase

    stall_nxt = stall_q;
    if (hazard && !bus.mem_stall && (stall_q != '1)) stall_nxt = stall_q + CNT_W'(1);

    wd_nxt = '0;
    if (TIMEOUT != 0 && hazard) begin
      wd_nxt = (wd_q == WD_W'(TIMEOUT)) ? wd_q : wd_q + WD_W'(1);
    end

    err_nxt = err_q || bad_clr || wd_expire;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the scoreboard is a flop vector, not RAM, so clearing it in reset is cheap and required.
      busy_q  <= '0;
      pend_q  <= '0;
      stall_q <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_nxt;
      pend_q  <= pend_nxt;
      stall_q <= stall_nxt;
      wd_q    <= wd_nxt;
      err_q   <= err_nxt;
    end
  end

  assign bus.hazard      = hazard;
  assign bus.pc_write    = rst || (!hazard && !bus.mem_stall);
  assign bus.if_id_write = rst || (!hazard && !bus.mem_stall);
  assign bus.ctrl_enable = !hazard;
  assign bus.busy_vec    = busy_q;
  assign bus.pending_cnt = pend_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: a bypassing instance plus a non-bypassing twin
// fed the same stimulus; expected outputs are queued per step and compared at the negedge.
module tb_hazard_scoreboard_unit;
  localparam int unsigned NUM_REGS = 32, REG_AW = 5, MAX_PENDING = 4, CNT_W = 16, TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)) a ();
  hazard_scoreboard_if #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)) b ();

  hazard_scoreboard_unit #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .MAX_PENDING(MAX_PENDING),
    .WB_BYPASS(1'b1), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_dut (.clk(clk), .rst(rst), .bus(a.slave));
  hazard_scoreboard_unit #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .MAX_PENDING(MAX_PENDING),
    .WB_BYPASS(1'b0), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_nobyp (.clk(clk), .rst(rst), .bus(b.slave));

  assign b.id_valid     = a.id_valid;
  assign b.id_rs1       = a.id_rs1;
  assign b.id_rs2       = a.id_rs2;
  assign b.id_use_rs1   = a.id_use_rs1;
  assign b.id_use_rs2   = a.id_use_rs2;
  assign b.id_rd        = a.id_rd;
  assign b.id_is_load   = a.id_is_load;
  assign b.id_branch    = a.id_branch;
  assign b.ex_regwrite  = a.ex_regwrite;
  assign b.ex_rd        = a.ex_rd;
  assign b.wb_load_done = a.wb_load_done;
  assign b.wb_rd        = a.wb_rd;
  assign b.mem_stall    = a.mem_stall;
  assign b.flush        = a.flush;

  typedef struct {
    string            tag;
    logic             hazard;
    logic             pc_write;
    logic             ctrl_enable;
    logic [2:0]       pend;
    logic             err;
    logic [CNT_W-1:0] stall;
    int               hz_b;
  } exp_t;

  exp_t             sb[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [CNT_W-1:0] exp_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a.id_valid = 0; a.id_rs1 = '0; a.id_rs2 = '0; a.id_use_rs1 = 0; a.id_use_rs2 = 0;
    a.id_rd = '0; a.id_is_load = 0; a.id_branch = 0; a.ex_regwrite = 0; a.ex_rd = '0;
    a.wb_load_done = 0; a.wb_rd = '0; a.mem_stall = 0; a.flush = 0;
  endtask

  task automatic id_in(input logic [4:0] rd, input logic ld, input logic [4:0] rs1, input logic u1);
    a.id_valid = 1; a.id_rd = rd; a.id_is_load = ld; a.id_rs1 = rs1; a.id_use_rs1 = u1;
    a.id_use_rs2 = 0; a.id_branch = 0;
  endtask

  task automatic wb_in(input logic d, input logic [4:0] rd);
    a.wb_load_done = d; a.wb_rd = rd;
  endtask

  // One pipeline cycle: queue the expectation for the driven inputs, compare at the negedge.
  task automatic cyc(input string tag, input logic hz, input int pend, input logic e, input int hzb = -1);
    exp_t x, y;
    x.tag = tag; x.hazard = hz; x.pc_write = !hz && !a.mem_stall; x.ctrl_enable = !hz;
    x.pend = 3'(pend); x.err = e; x.stall = exp_stall; x.hz_b = hzb;
    sb.push_back(x);
    @(negedge clk);
    y = sb.pop_front();
    chk({y.tag, ":hazard"},      64'(a.hazard),      64'(y.hazard));
    chk({y.tag, ":pc_write"},    64'(a.pc_write),    64'(y.pc_write));
    chk({y.tag, ":if_id_write"}, 64'(a.if_id_write), 64'(y.pc_write));
    chk({y.tag, ":ctrl_enable"}, 64'(a.ctrl_enable), 64'(y.ctrl_enable));
    chk({y.tag, ":pending_cnt"}, 64'(a.pending_cnt), 64'(y.pend));
    chk({y.tag, ":err"},         64'(a.err),         64'(y.err));
    chk({y.tag, ":stall_cnt"},   64'(a.stall_cnt),   64'(y.stall));
    if (y.hz_b >= 0) chk({y.tag, ":hazard_nobyp"}, 64'(b.hazard), 64'(y.hz_b));
    if (hz && !a.mem_stall && exp_stall != '1) exp_stall++;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset with a live branch hazard on the inputs: outputs must stay in the no-stall state.
    rst = 1; idle(); exp_stall = '0;
    a.id_valid = 1; a.id_branch = 1; a.id_use_rs1 = 1; a.id_rs1 = 7; a.ex_regwrite = 1; a.ex_rd = 7;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst_hold", 0, 0, 0);
    rst = 0; idle();
    cyc("post_rst", 0, 0, 0);
    chk("post_rst:busy", 64'(a.busy_vec), 64'h0);

    // Load x5, dependent add, writeback three cycles after issue.
    id_in(5, 1, 0, 0);  cyc("ld_x5",    0, 0, 0, 0);
    id_in(8, 0, 5, 1);  cyc("raw_c1",   1, 1, 0, 1);
    chk("raw_c1:busy", 64'(a.busy_vec), 64'h20);
    cyc("raw_c2",   1, 1, 0, 1);
    wb_in(1, 5);        cyc("raw_wb",   0, 1, 0, 1);
    wb_in(0, 0);        cyc("raw_done", 0, 0, 0, 0);
    chk("nobyp:stall_cnt",   64'(b.stall_cnt),   64'd3);
    chk("nobyp:pending_cnt", 64'(b.pending_cnt), 64'd0);
    idle();

    // Branch in ID against an ALU result still in EX.
    a.id_valid = 1; a.id_branch = 1; a.id_use_rs1 = 1; a.id_rs1 = 7; a.id_use_rs2 = 1; a.id_rs2 = 3;
    a.ex_regwrite = 1; a.ex_rd = 7;            cyc("br_ex",     1, 0, 0);
    a.ex_regwrite = 0;                         cyc("br_bubble", 0, 0, 0);
    a.ex_regwrite = 1; a.ex_rd = 0; a.id_rs1 = 0; cyc("br_x0",  0, 0, 0);
    a.ex_rd = 3; a.id_use_rs2 = 0;             cyc("br_nouse",  0, 0, 0);
    a.id_use_rs2 = 1;                          cyc("br_rs2",    1, 0, 0);
    idle();

    // Fill the outstanding-load limit, then a fifth load.
    for (int i = 1; i <= 4; i++) begin
      id_in(5'(i), 1, 0, 0); cyc("fill", 0, i - 1, 0);
    end
    id_in(6, 1, 0, 0);          cyc("full_1", 1, 4, 0);
    cyc("full_2", 1, 4, 0);
    wb_in(1, 1); a.mem_stall = 1; cyc("full_wb_ms", 0, 4, 0);
    wb_in(0, 0); a.mem_stall = 0; cyc("full_go",    0, 3, 0);
    idle();                     cyc("full_after", 0, 4, 0);
    chk("full_after:busy", 64'(a.busy_vec), 64'h5C);
    wb_in(1, 2); cyc("drain_2", 0, 4, 0);
    wb_in(1, 3); cyc("drain_3", 0, 3, 0);
    wb_in(1, 4); cyc("drain_4", 0, 2, 0);
    wb_in(1, 6); cyc("drain_6", 0, 1, 0);
    wb_in(0, 0); cyc("drained", 0, 0, 0);
    chk("drained:busy", 64'(a.busy_vec), 64'h0);

    // Writeback of x9 coinciding with a new load to x9.
    id_in(9, 1, 0, 0);               cyc("x9_ld",    0, 0, 0);
    id_in(9, 1, 0, 0); wb_in(1, 9);  cyc("x9_both",  0, 1, 0);
    idle();                          cyc("x9_after", 0, 1, 0);
    chk("x9_after:busy", 64'(a.busy_vec), 64'h200);
    wb_in(1, 9);                     cyc("x9_wb",    0, 1, 0);
    wb_in(0, 0);                     cyc("x9_clr",   0, 0, 0);
    id_in(0, 1, 0, 0);               cyc("ld_x0",    0, 0, 0);
    idle();                          cyc("ld_x0_after", 0, 0, 0);

    // Flush of a stalled dependent load: no stall and no scoreboard entry.
    id_in(10, 1, 0, 0);                 cyc("fl_ld",     0, 0, 0);
    id_in(11, 1, 10, 1); a.flush = 1;   cyc("flush",     0, 1, 0);
    a.flush = 0;                        cyc("flush_off", 1, 1, 0);
    idle();                             cyc("fl_idle",   0, 1, 0);
    chk("fl_idle:busy", 64'(a.busy_vec), 64'h400);
    wb_in(1, 10);                       cyc("fl_wb",     0, 1, 0);
    wb_in(0, 0);                        cyc("fl_done",   0, 0, 0);

    // Watchdog: 255 consecutive hazard cycles raise err at the end of the last one.
    id_in(5, 1, 0, 0); cyc("wd_ld", 0, 0, 0);
    id_in(8, 0, 5, 1);
    for (int k = 0; k < 255; k++) cyc("wd_hold", 1, 1, 0);
    cyc("wd_err", 1, 1, 1);
    wb_in(1, 5);       cyc("wd_rel",    0, 1, 1);
    idle();            cyc("wd_sticky", 0, 0, 1);

    // Reset clears err; a clear of a non-busy register sets it; reset mid-load drops tracking.
    rst = 1; idle(); exp_stall = '0;
    @(posedge clk); #1;
    rst = 0;                      cyc("rst2",    0, 0, 0);
    id_in(13, 1, 0, 0);           cyc("ld_x13",  0, 0, 0);
    idle(); wb_in(1, 12);         cyc("bad_clr", 0, 1, 0);
    wb_in(0, 0);                  cyc("bad_err", 0, 1, 1);
    rst = 1; exp_stall = '0;
    @(posedge clk); #1;
    rst = 0;                      cyc("rst_mid", 0, 0, 0);
    chk("rst_mid:busy", 64'(a.busy_vec), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
